// File: rtl/hazard_pkg.sv
// hazard_pkg: opcodes, shadow-pipe entry type and depth shared by the hazard unit
package hazard_pkg;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] SYSTEM = 7'b1110011;
  localparam int SB_DEPTH = 3;
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       ld;
  } sb_entry_t;
endpackage

// File: rtl/hazard_scoreboard_rs_use_decode.sv
// rs_use_decode: which source register fields an opcode actually reads
module rs_use_decode
  import hazard_pkg::*;
(
  input  logic [6:0] i_opcode,
  output logic       o_rs1_used,
  output logic       o_rs2_used
);
  assign o_rs1_used = i_opcode inside {OP, OP_IMM, LOAD, STORE, BRANCH, JALR, SYSTEM};
  assign o_rs2_used = i_opcode inside {OP, STORE, BRANCH};
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode-stage RAW stall unit with EX/MEM/WB shadow pipe and stall counter
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter bit FWD_EN         = 1'b0,
  parameter bit RF_WRITE_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_ID,
  input  logic        valid_ID,
  input  logic        regWEn_ID,
  input  logic        memRead_ID,
  input  logic        flush_EX,
  output logic        stall_ID,
  output logic        bubble_EX,
  output logic [31:0] pending_mask,
  output logic [31:0] stall_cnt
);
  sb_entry_t [SB_DEPTH-1:0] r_pipe;
  logic [31:0]         r_cnt;
  logic [4:0]          w_rs1, w_rs2, w_rd;
  logic                w_rs1_used, w_rs2_used, w_raw, w_e1_v, w_unused;
  logic [SB_DEPTH-1:0] w_match;
  assign w_rs1 = inst_ID[19:15];
  assign w_rs2 = inst_ID[24:20];
  assign w_rd  = inst_ID[11:7];
  assign w_unused = ^{inst_ID[31:25], inst_ID[14:12]};
  rs_use_decode u_dec (
    .i_opcode  (inst_ID[6:0]),
    .o_rs1_used(w_rs1_used),
    .o_rs2_used(w_rs2_used)
  );
  always_comb begin
    w_match      = '0;
    pending_mask = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      w_match[k] = r_pipe[k].v & ((w_rs1_used & (r_pipe[k].rd == w_rs1)) |
                                  (w_rs2_used & (r_pipe[k].rd == w_rs2)));
      pending_mask = pending_mask | (r_pipe[k].v ? (32'd1 << r_pipe[k].rd) : 32'd0);
    end
    pending_mask[0] = 1'b0;
  end
  // forwarding covers everything except a load still in EX
  assign w_raw = FWD_EN ? (w_match[0] & r_pipe[0].ld)
                        : (w_match[0] | w_match[1] | (~RF_WRITE_FIRST & w_match[2]));
  assign stall_ID  = valid_ID & w_raw & ~flush_EX;
  assign bubble_EX = stall_ID | flush_EX;
  assign w_e1_v    = valid_ID & regWEn_ID & (w_rd != 5'd0) & ~stall_ID & ~flush_EX;
  assign stall_cnt = r_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pipe <= '0;
      r_cnt  <= '0;
    end else begin
      r_pipe[2] <= r_pipe[1];
      r_pipe[1] <= flush_EX ? '0 : r_pipe[0];
      r_pipe[0] <= '{v: w_e1_v, rd: w_rd, ld: w_e1_v & memRead_ID};
      if (stall_ID && !(&r_cnt)) r_cnt <= r_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed vectors over non-forwarding (both RF modes) and forwarding builds
module tb_hazard_scoreboard;
  logic        clk = 1'b0;
  logic        rst, vld, we, mr, fl;
  logic [31:0] inst;
  logic        st_nf, bb_nf, st_n3, bb_n3, st_fw, bb_fw;
  logic [31:0] pm_nf, sc_nf, pm_n3, sc_n3, pm_fw, sc_fw;
  int n_vec = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  hazard_scoreboard #(.FWD_EN(1'b0), .RF_WRITE_FIRST(1'b1)) u_nf (
    .clk(clk), .rst(rst), .inst_ID(inst), .valid_ID(vld), .regWEn_ID(we), .memRead_ID(mr),
    .flush_EX(fl), .stall_ID(st_nf), .bubble_EX(bb_nf), .pending_mask(pm_nf), .stall_cnt(sc_nf));
  hazard_scoreboard #(.FWD_EN(1'b0), .RF_WRITE_FIRST(1'b0)) u_n3 (
    .clk(clk), .rst(rst), .inst_ID(inst), .valid_ID(vld), .regWEn_ID(we), .memRead_ID(mr),
    .flush_EX(fl), .stall_ID(st_n3), .bubble_EX(bb_n3), .pending_mask(pm_n3), .stall_cnt(sc_n3));
  hazard_scoreboard #(.FWD_EN(1'b1), .RF_WRITE_FIRST(1'b1)) u_fw (
    .clk(clk), .rst(rst), .inst_ID(inst), .valid_ID(vld), .regWEn_ID(we), .memRead_ID(mr),
    .flush_EX(fl), .stall_ID(st_fw), .bubble_EX(bb_fw), .pending_mask(pm_fw), .stall_cnt(sc_fw));
  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic [31:0] i, input logic v, input logic w, input logic m, input logic f);
    inst = i; vld = v; we = w; mr = m; fl = f;
    #1;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    drive(32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
  endtask
  function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [6:0] f7);
    return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] itype(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [6:0] op);
    return {12'd0, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] lui(input logic [4:0] rd, input logic [4:0] rs1f);
    return {12'h000, rs1f, 3'b000, rd, 7'b0110111};
  endfunction
  initial begin
    do_reset();
    drive(32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_eq("rst_pending", pm_nf, 32'd0);
    expect_eq("rst_stall", {31'd0, st_nf}, 32'd0);
    expect_eq("rst_bubble_flush", {31'd0, bb_nf}, 32'd1);
    expect_eq("rst_cnt", sc_nf, 32'd0);
    // back-to-back RAW: add x5,x1,x2 ; add x6,x5,x3
    do_reset();
    drive(rtype(5'd5, 5'd1, 5'd2, 7'd0), 1'b1, 1'b1, 1'b0, 1'b0);
    expect_eq("raw_prod_nostall", {31'd0, st_nf}, 32'd0);
    tick();
    drive(rtype(5'd6, 5'd5, 5'd3, 7'd0), 1'b1, 1'b1, 1'b0, 1'b0);
    expect_eq("raw_c1_stall", {31'd0, st_nf}, 32'd1);
    expect_eq("raw_c1_bubble", {31'd0, bb_nf}, 32'd1);
    expect_eq("raw_c1_pending", pm_nf, 32'h0000_0020);
    expect_eq("raw_c1_fw_nostall", {31'd0, st_fw}, 32'd0);
    tick();
    expect_eq("raw_c2_stall", {31'd0, st_nf}, 32'd1);
    expect_eq("raw_c2_bubble", {31'd0, bb_nf}, 32'd1);
    tick();
    expect_eq("raw_c3_release", {31'd0, st_nf}, 32'd0);
    expect_eq("raw_c3_wb_stall_rf0", {31'd0, st_n3}, 32'd1);
    expect_eq("raw_cnt2", sc_nf, 32'd2);
    tick();
    expect_eq("raw_c4_rf0_release", {31'd0, st_n3}, 32'd0);
    expect_eq("raw_cnt3_rf0", sc_n3, 32'd3);
    expect_eq("raw_cnt2_hold", sc_nf, 32'd2);
    // load-use with forwarding: lw x7,0(x1) ; sub x8,x7,x2
    do_reset();
    drive(itype(5'd7, 5'd1, 3'b010, 7'b0000011), 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    drive(rtype(5'd8, 5'd7, 5'd2, 7'b0100000), 1'b1, 1'b1, 1'b0, 1'b0);
    expect_eq("lu_stall", {31'd0, st_fw}, 32'd1);
    tick();
    expect_eq("lu_release", {31'd0, st_fw}, 32'd0);
    expect_eq("lu_cnt1", sc_fw, 32'd1);
    do_reset();
    drive(rtype(5'd7, 5'd1, 5'd2, 7'd0), 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(rtype(5'd8, 5'd7, 5'd2, 7'b0100000), 1'b1, 1'b1, 1'b0, 1'b0);
    expect_eq("alu_use_fw_nostall", {31'd0, st_fw}, 32'd0);
    tick();
    expect_eq("alu_use_fw_cnt0", sc_fw, 32'd0);
    // write to x0 never tracked
    do_reset();
    drive(itype(5'd0, 5'd1, 3'b000, 7'b0010011), 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(rtype(5'd2, 5'd0, 5'd0, 7'd0), 1'b1, 1'b1, 1'b0, 1'b0);
    expect_eq("x0_pending", pm_n3, 32'd0);
    expect_eq("x0_nostall", {31'd0, st_n3}, 32'd0);
    // lui ignores its rs1 field
    do_reset();
    drive(lui(5'd5, 5'd0), 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(lui(5'd6, 5'd5), 1'b1, 1'b1, 1'b0, 1'b0);
    expect_eq("lui_pending", pm_n3, 32'h0000_0020);
    expect_eq("lui_nostall", {31'd0, st_n3}, 32'd0);
    // flush kills a load-use stall
    do_reset();
    drive(itype(5'd9, 5'd1, 3'b010, 7'b0000011), 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    drive(rtype(5'd10, 5'd9, 5'd9, 7'd0), 1'b1, 1'b1, 1'b0, 1'b1);
    expect_eq("fl_pending_pre", pm_fw, 32'h0000_0200);
    expect_eq("fl_stall_fw", {31'd0, st_fw}, 32'd0);
    expect_eq("fl_bubble_fw", {31'd0, bb_fw}, 32'd1);
    expect_eq("fl_stall_nf", {31'd0, st_nf}, 32'd0);
    tick();
    drive(32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_eq("fl_pending_post", pm_fw, 32'd0);
    tick();
    expect_eq("fl_e2_empty", pm_fw, 32'd0);
    // reset during a stall
    do_reset();
    drive(rtype(5'd5, 5'd1, 5'd2, 7'd0), 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(rtype(5'd6, 5'd5, 5'd3, 7'd0), 1'b1, 1'b1, 1'b0, 1'b0);
    expect_eq("rs_stall_pre", {31'd0, st_nf}, 32'd1);
    tick();
    expect_eq("rs_cnt1", sc_nf, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    expect_eq("rs_pending", pm_nf, 32'd0);
    expect_eq("rs_stall", {31'd0, st_nf}, 32'd0);
    expect_eq("rs_cnt", sc_nf, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
